// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencing controller for a 4-bit unsigned restoring divider.
// One subtract-mode add_sub datapath (a - b, carry-out = no borrow) is stepped
// through four iterations, one per clock, to produce quotient and remainder.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   divide request, honoured only in IDLE or DONE
//   dividend     in   [3:0] unsigned dividend, captured on accepted start
//   divisor      in   [3:0] unsigned divisor, captured on accepted start
//   busy         out  high while iterating (RUN)
//   done         out  one-cycle strobe, results valid
//   quotient     out  [3:0] held until the next result
//   remainder    out  [3:0] held until the next result
//   div_by_zero  out  set with done when the captured divisor was 0
module div_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] d_q, d_d;       // latched divisor
    logic [3:0] r_q, r_d;       // partial remainder
    logic [3:0] q_q, q_d;       // dividend shifting out, quotient shifting in
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] quot_q, quot_d;
    logic [3:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;

    // Datapath for one restoring step.
    logic       m;
    logic [3:0] r4;
    logic [4:0] sub;
    logic       c;
    logic       qb;
    logic [3:0] r_new;
    logic [3:0] q_new;

    always_comb begin
        m     = r_q[3];
        r4    = {r_q[2:0], q_q[3]};
        // Subtract-mode add_sub: sub[4] is the borrow, so carry c = ~borrow.
        sub   = {1'b0, r4} - {1'b0, d_q};
        c     = ~sub[4];
        // With m set the shifted value is >= 16 > D, so the subtract always
        // succeeds and the low 4 bits of the difference are still correct.
        qb    = m | c;
        r_new = qb ? sub[3:0] : r4;
        q_new = {q_q[2:0], qb};
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = 4'd0;
                    cnt_d = 2'd0;
                    if (divisor == 4'd0) begin
                        state_d = StDone;
                        quot_d  = 4'hF;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                r_d   = r_new;
                q_d   = q_new;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StDone;
                    quot_d  = q_new;
                    rem_d   = r_new;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            d_q     <= 4'd0;
            r_q     <= 4'd0;
            q_q     <= 4'd0;
            cnt_q   <= 2'd0;
            quot_q  <= 4'd0;
            rem_q   <= 4'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs decode registered state only; no path from start.
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequencing controller for a 4-bit unsigned restoring divider. It drives one shared add_sub instance, hard-wired to subtract mode (swi=1), over four iterations. It sits beside the adder datapath as the multi-cycle divide unit. It takes a start pulse and returns quotient and remainder with a one-cycle done strobe.

Parameters:
None. Width is fixed at 4 by the add_sub datapath.

Ports:
clk          input   1  system clock, rising edge
rst          input   1  synchronous reset, active-high
start        input   1  request a divide; sampled only in IDLE or DONE
dividend     input   4  unsigned dividend, captured on the accepted start edge
divisor      input   4  unsigned divisor, captured on the accepted start edge
busy         output  1  high while the divide is in progress (RUN)
done         output  1  one-cycle strobe; results valid
quotient     output  4  unsigned quotient, held until the next accepted start
remainder    output  4  unsigned remainder, held until the next accepted start
div_by_zero  output  1  set with done when the captured divisor is 0; held like the results

Behaviour:
- Reset (rst=1 at a clk edge): the state goes to IDLE. busy, done, div_by_zero, quotient and remainder all go to 0. Reset has priority over every other input, including mid-RUN; an in-flight divide is discarded with no done.
- Internal registers:
  - D (4b): latched divisor
  - R (4b): partial remainder
  - Q (4b): dividend shifting into the quotient
  - cnt (2b): iteration counter
- States and transitions:
  - IDLE:
    - start=1 -> latch D=divisor, Q=dividend, R=0, cnt=0.
    - If divisor==0, go to DONE with quotient=4'hF, remainder=dividend, div_by_zero=1.
    - Otherwise clear div_by_zero and go to RUN.
  - RUN: one iteration per clock.
    - Form the 5-bit shifted value {m, r4} = {R, Q[3]}, where m is the old R[3].
    - Drive add_sub with a=r4, b=D, swi=1. It returns diff (4b) and carry c; c=1 means no borrow.
    - Quotient bit qb = m | c. When m=1 the true value is at least 16, which exceeds D, so the subtract is always valid and diff is correct modulo 16.
    - Update R = qb ? diff : r4 and Q = {Q[2:0], qb}, then cnt = cnt+1.
    - When cnt==3, take this last iteration and go to DONE, with quotient=new Q and remainder=new R.
  - DONE:
    - done=1 for exactly this one cycle.
    - start=1 is accepted exactly as in IDLE, so back-to-back divides are allowed.
    - Otherwise go to IDLE.
- busy=1 exactly while the state is RUN; done=1 exactly while the state is DONE. Both are registered outputs with no combinational path from start.
- Latency:
  - Accepted start at edge E0 -> RUN during E0..E4 -> done high in the cycle after E4, i.e. 4 cycles after E0.
  - Divide-by-zero: done is high in the cycle after E0.
- While busy, start is ignored and the dividend/divisor inputs are don't-care. The operands are frozen in D/Q/R.
- quotient, remainder and div_by_zero update only when entering DONE (or on reset). They stay stable from done through IDLE until the next result.
- Results must match the reference: quotient = dividend / divisor and remainder = dividend % divisor for every divisor != 0.

Test Plan:
- Reset, then start with 13/4 -> busy for 4 cycles; done 4 cycles after the start edge with quotient=3, remainder=1, div_by_zero=0. Results still 3/1 five cycles later.
- 15/1 -> quotient=15, remainder=0. Then 3/7 -> quotient=0, remainder=3. Then 15/15 -> quotient=1, remainder=0. Covers the m=1 path and the all-restore path.
- 9/0 -> busy never rises; done one cycle after start with div_by_zero=1, quotient=4'hF, remainder=9. A following 8/2 -> div_by_zero=0, quotient=4, remainder=0.
- Start 12/5 with start held high, inputs changed to 1/1 during RUN -> result quotient=2, remainder=2. Start re-asserted in the DONE cycle with 7/2 -> quotient=3, remainder=1 exactly 4 cycles later.
- Start 14/3, rst asserted on the 2nd RUN edge -> all outputs 0 in the next cycle, no done ever. A new start 14/3 then gives quotient=4, remainder=2.
- Exhaustive sweep of all 256 dividend/divisor pairs, back-to-back -> every result matches integer divide/modulo, div_by_zero exactly when divisor==0, one done per accepted start.
